dualrail_tx_bridge: RTL and testbench



---
 rtl/dualrail_tx_bridge_pkg.sv | 15 +
 rtl/dualrail_tx_bridge_fifo.sv | 53 +++++
 rtl/dualrail_tx_bridge.sv | 113 +++++++++++
 tb/tb_dualrail_tx_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dualrail_tx_bridge_pkg.sv
// Shared definitions for the dual-rail bridges: FSM state codes, null rail pair
// and the per-bit 1-of-2 encoder used to build a token.
package dualrail_tx_bridge_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DATA = 1'b1;

  localparam logic [1:0] DR_NULL_PAIR = 2'b00;

  // Rail pair for one data bit: {rail-1, rail-0}. Never 2'b11.
  function automatic logic [1:0] dr_pair(input logic b);
    return {b, ~b};
  endfunction

endpackage

// File: rtl/dualrail_tx_bridge_fifo.sv
// bridge_fifo: synchronous FIFO with wrap-bit pointers, no push/pop bypass.
// A push is refused whenever the FIFO is full, even if a pop happens on the same edge.
module bridge_fifo
  import dualrail_tx_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dualrail_tx_bridge.sv
// Synchronous valid/ready word stream to WIDTH-bit dual-rail four-phase channel
// with enable-style acknowledge Le, Le synchroniser and a sticky handshake watchdog.
module dualrail_tx_bridge
  import dualrail_tx_bridge_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*WIDTH-1:0]     L,
  input  logic                   Le,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  logic [SYNC_STAGES-1:0] le_sync;
  logic                   le_s;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic [WIDTH-1:0]       head;
  logic [2*WIDTH-1:0]     enc;
  logic [2*WIDTH-1:0]     l_reg;
  logic                   state;

  // Le is asynchronous to clk; only the last synchroniser stage may be used.
  always_ff @(posedge clk) begin
    if (reset) le_sync <= '0;
    else       le_sync <= {le_sync[SYNC_STAGES-2:0], Le};
  end
  assign le_s = le_sync[SYNC_STAGES-1];

  bridge_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign in_ready = !full;
  assign pop      = (state == ST_IDLE) && !empty && le_s;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      enc[2*i +: 2] = dr_pair(head[i]);
    end
  end

  // L is driven straight from l_reg so all rails switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      l_reg <= '0;
    end else if (state == ST_IDLE) begin
      if (pop) begin
        l_reg <= enc;
        state <= ST_DATA;
      end
    end else begin
      if (!le_s) begin
        l_reg <= '0;
        state <= ST_IDLE;
      end
    end
  end
  assign L = l_reg;

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] wd_cnt;
      logic          err_q;

      // Counter saturates at TIMEOUT; err is sticky and the token is kept.
      always_ff @(posedge clk) begin
        if (reset) begin
          wd_cnt <= '0;
          err_q  <= 1'b0;
        end else begin
          if (pop) begin
            wd_cnt <= '0;
          end else if (state == ST_DATA && wd_cnt != CW'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
          if (state == ST_DATA && wd_cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
          end
        end
      end
      assign err = err_q;
    end else begin : g_no_wd
      assign err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_dualrail_tx_bridge.sv
// Self-checking bench for dualrail_tx_bridge: queue-based reference model compared
// every cycle, a randomised four-phase receiver, and directed literal checks.
module tb_dualrail_tx_bridge;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2*WIDTH-1:0] L;
  logic             Le;
  logic [LW-1:0]    level;
  logic             err;

  logic le_man = 1'b1;
  logic le_rx  = 1'b1;
  logic rx_en  = 1'b0;
  logic chk_en = 1'b0;
  assign Le = rx_en ? le_rx : le_man;

  always #5 clk = ~clk;

  dualrail_tx_bridge #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .L        (L),
    .Le       (Le),
    .level    (level),
    .err      (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] dec(input logic [2*WIDTH-1:0] v);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[i] = v[2*i+1];
    return w;
  endfunction

  function automatic logic well_formed(input logic [2*WIDTH-1:0] v);
    if (v == '0) return 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[2*i +: 2] != 2'b01 && v[2*i +: 2] != 2'b10) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: occupancy as a queue, Le seen through a SYNC-deep delay,
  // and a single "token on the wire" slot with a DATA-cycle counter.
  logic [WIDTH-1:0] m_q[$];
  logic [SYNC-1:0]  m_pipe;
  logic             m_tok;
  logic [WIDTH-1:0] m_word;
  int               m_cnt;
  logic             m_err;
  logic             m_les;
  logic             m_can_push;
  logic             m_do_pop;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_pipe = '0;
      m_tok  = 1'b0;
      m_word = '0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      m_les      = m_pipe[SYNC-1];
      m_can_push = in_valid && (m_q.size() < DEPTH);
      m_do_pop   = !m_tok && (m_q.size() > 0) && m_les;
      if (m_tok) begin
        if (m_cnt < TIMEOUT) m_cnt++;
        if (m_cnt == TIMEOUT) m_err = 1'b1;
        if (!m_les) m_tok = 1'b0;
      end else if (m_do_pop) begin
        m_word = m_q.pop_front();
        m_tok  = 1'b1;
        m_cnt  = 0;
      end
      if (m_can_push) m_q.push_back(in_data);
      m_pipe = {m_pipe[SYNC-2:0], Le};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("L", L, m_tok ? enc(m_word) : '0);
      check("level", level, m_q.size());
      check("in_ready", in_ready, m_q.size() < DEPTH);
      check("err", err, m_err);
      check("L_code", well_formed(L), 1'b1);
    end
  end

  // Four-phase receiver with random 0-5 cycle reaction delays.
  logic [WIDTH-1:0] sent[$];
  int rx_phase = 0;
  int rx_idx   = 0;
  int rx_cd    = 0;

  always @(negedge clk) begin
    if (!rx_en) begin
      rx_phase = 0;
      rx_idx   = 0;
      le_rx    = 1'b1;
    end else begin
      case (rx_phase)
        0: if (L != '0) begin
             if (rx_idx < sent.size()) check("rx_word", dec(L), sent[rx_idx]);
             else expired("rx_unexpected_token");
             rx_idx++;
             rx_cd    = $urandom_range(0, 5);
             rx_phase = 1;
           end
        1: if (rx_cd == 0) begin le_rx = 1'b0; rx_phase = 2; end else rx_cd--;
        2: if (L == '0) begin rx_cd = $urandom_range(0, 5); rx_phase = 3; end
        default: if (rx_cd == 0) begin le_rx = 1'b1; rx_phase = 0; end else rx_cd--;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
        sent.push_back(d);
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    expired("push");
  endtask

  task automatic apply_reset();
    rx_en = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sent.delete();
    chk_en = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int i;
    for (i = 0; i < budget && !(rx_idx == n && rx_phase == 0); i++) tick(1);
    if (i == budget) expired("rx_drain");
    check("rx_count", rx_idx, n);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state and first token
    le_man = 1'b1;
    apply_reset();
    check("rst_L", L, 16'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_level", level, 0);
    check("rst_err", err, 1'b0);
    tick(3);
    push_word(8'hA5);
    check("a5_level_after_push", level, 1);
    check("a5_L_null_after_push", L, 16'h0);
    tick(1);
    check("a5_L", L, 16'b1001_1001_0110_0110);
    check("a5_level_after_pop", level, 0);
    le_man = 1'b0;
    tick(2);
    check("a5_L_held", L, 16'b1001_1001_0110_0110);
    tick(1);
    check("a5_L_null", L, 16'h0);
    le_man = 1'b1;
    tick(3);

    // Fill the FIFO with the receiver stalled, extra word held at the input
    apply_reset();
    tick(3);
    for (int w = 0; w < 5; w++) push_word(8'hB0 + 8'(w));
    in_valid = 1'b1;
    in_data  = 8'hB5;
    tick(2);
    check("full_in_ready", in_ready, 1'b0);
    check("full_level", level, DEPTH);
    check("full_L", L, 16'h9A55);
    le_man = 1'b0;
    tick(3);
    check("full_L_null", L, 16'h0);
    le_man = 1'b1;
    begin
      int i;
      for (i = 0; i < 20 && !in_ready; i++) tick(1);
      if (i == 20) expired("full_reaccept");
    end
    tick(1);
    in_valid = 1'b0;
    sent.push_back(8'hB5);
    check("full_level_refill", level, DEPTH);
    void'(sent.pop_front());
    rx_en = 1'b1;
    wait_rx(5, 500);
    rx_en = 1'b0;

    // Watchdog
    apply_reset();
    tick(3);
    push_word(8'h3C);
    tick(16);
    check("wd_err_before", err, 1'b0);
    tick(1);
    check("wd_err_set", err, 1'b1);
    check("wd_L_kept", L, 16'h5AA5);
    le_man = 1'b0;
    tick(4);
    check("wd_err_sticky", err, 1'b1);
    check("wd_L_null", L, 16'h0);
    le_man = 1'b1;
    tick(3);
    check("wd_err_sticky2", err, 1'b1);
    apply_reset();
    check("wd_err_cleared", err, 1'b0);

    // Reset mid-handshake with Le low
    tick(3);
    push_word(8'h11);
    push_word(8'h22);
    le_man = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    check("rst_mid_L", L, 16'h0);
    check("rst_mid_level", level, 0);
    reset = 1'b0;
    sent.delete();
    push_word(8'h77);
    tick(6);
    check("rst_mid_wait_L", L, 16'h0);
    check("rst_mid_wait_level", level, 1);
    le_man = 1'b1;
    tick(2);
    check("rst_mid_L_sync", L, 16'h0);
    tick(1);
    check("rst_mid_L_data", L, 16'h6A6A);
    check("rst_mid_level_pop", level, 0);
    le_man = 1'b0;
    tick(4);
    le_man = 1'b1;

    // Simultaneous push and pop at level 2
    apply_reset();
    tick(3);
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    check("pp_level_before", level, 2);
    le_man = 1'b0;
    tick(3);
    le_man = 1'b1;
    tick(2);
    push_word(8'hC4);
    check("pp_level_after", level, 2);
    check("pp_L", L, 16'hA559);
    void'(sent.pop_front());
    rx_en = 1'b1;
    wait_rx(3, 500);
    rx_en = 1'b0;

    // Streamed 0x00..0xFF against the random receiver
    apply_reset();
    tick(3);
    rx_en = 1'b1;
    for (int w = 0; w < 256; w++) push_word(8'(w));
    wait_rx(256, 20000);
    check("stream_level", level, 0);
    check("stream_err", err, 1'b0);
    rx_en = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
